// File: rtl/cache_dre_ctrl.sv
// cache_dre_ctrl
//   Sequencer and arbiter for the byte-readable (DRE) RAM of the data cache.
//   It owns the ri_* write port and the sel mux of cache_rw_dre. It clears
//   every DRE entry after reset and on flush-all. It also performs single-line
//   invalidate/fill writes for the refill engine, and it stalls the rw
//   pipeline (rw_grant=0) only in the cycles where it writes the RAM.
//
// Ports
//   clk, rst           : clock and synchronous active-high reset
//   cmd_valid/ready    : command handshake; cmd_op 00 flush, 01 inv, 10 fill, 11 nop
//   cmd_addr, cmd_ch   : line address (bit 0 selects nibble) and way/channel
//   rw_req, rw_grant   : rw pipeline request and grant (grant is ~sel)
//   sel                : cache_rw_dre mux select, 1 routes ri_* to the RAM
//   ri_write*          : DRE write port (address, channel, enable, data)
//   busy, done         : operation in progress / one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CLR       | clear walk over all entries x channels (also the reset state)
// IDLE      | rw pipeline owns the RAM, commands accepted
// LINE_WAIT | line op pending, yields to rw_req for at most STARVE_LIMIT cycles
// LINE_WR   | the single line write is on the ri_* port

module cache_dre_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_ch,
  input  logic                  rw_req,
  output logic                  rw_grant,
  output logic                  sel,
  output logic [ADDR_WIDTH-1:0] ri_writeAddress,
  output logic [1:0]            ri_writeChannel,
  output logic                  ri_writeEnable,
  output logic [7:0]            ri_writeData,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {CLR, IDLE, LINE_WAIT, LINE_WR} stateT;

  // Walk index is {entry, channel}; channel is the low (inner) field.
  localparam logic [ADDR_WIDTH:0] WalkOne    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          StarveInit = 4'(STARVE_LIMIT);

  stateT                 state, stateNext;
  logic [ADDR_WIDTH:0]   walkCnt, walkNext;
  logic [3:0]            waitCnt, waitNext;
  logic [ADDR_WIDTH-1:0] lineAddr, lineAddrNext;
  logic [1:0]            lineCh, lineChNext;
  logic                  lineFill, lineFillNext;

  logic                  selNext, weNext, readyNext, grantNext, busyNext, doneNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [1:0]            chNext;
  logic [7:0]            dataNext;
  logic [7:0]            lineData;

  assign lineData = !lineFill   ? 8'h00 :
                    lineAddr[0] ? 8'hF0 : 8'h0F;

  always_comb begin
    stateNext    = state;
    walkNext     = walkCnt;
    waitNext     = waitCnt;
    lineAddrNext = lineAddr;
    lineChNext   = lineCh;
    lineFillNext = lineFill;
    selNext      = 1'b0;
    weNext       = 1'b0;
    addrNext     = '0;
    chNext       = '0;
    dataNext     = 8'h00;
    readyNext    = 1'b0;
    grantNext    = 1'b1;
    busyNext     = 1'b1;
    doneNext     = 1'b0;

    case (state)
      CLR: begin
        // Index back at 0 after a write means the last entry just went out.
        // Right after reset no write has happened yet, so the walk starts.
        if (ri_writeEnable && (walkCnt == '0)) begin
          stateNext = IDLE;
          readyNext = 1'b1;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
        end else begin
          selNext   = 1'b1;
          weNext    = 1'b1;
          grantNext = 1'b0;
          addrNext  = {walkCnt[ADDR_WIDTH:2], 1'b0};
          chNext    = walkCnt[1:0];
          walkNext  = walkCnt + WalkOne;
        end
      end

      IDLE: begin
        readyNext = 1'b1;
        busyNext  = 1'b0;
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            2'b00: begin
              // First clear write goes out in the cycle right after accept.
              stateNext = CLR;
              readyNext = 1'b0;
              busyNext  = 1'b1;
              selNext   = 1'b1;
              weNext    = 1'b1;
              grantNext = 1'b0;
              walkNext  = WalkOne;
            end
            2'b01, 2'b10: begin
              stateNext    = LINE_WAIT;
              readyNext    = 1'b0;
              busyNext     = 1'b1;
              lineAddrNext = cmd_addr;
              lineChNext   = cmd_ch;
              lineFillNext = cmd_op[1];
              waitNext     = StarveInit;
            end
            default: doneNext = 1'b1;
          endcase
        end
      end

      LINE_WAIT: begin
        if (!rw_req || (waitCnt == '0)) begin
          stateNext = LINE_WR;
          selNext   = 1'b1;
          weNext    = 1'b1;
          grantNext = 1'b0;
          addrNext  = lineAddr;
          chNext    = lineCh;
          dataNext  = lineData;
        end else begin
          waitNext = waitCnt - 4'd1;
        end
      end

      LINE_WR: begin
        stateNext = IDLE;
        readyNext = 1'b1;
        busyNext  = 1'b0;
        doneNext  = 1'b1;
      end

      default: stateNext = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= CLR;
      walkCnt         <= '0;
      waitCnt         <= '0;
      lineAddr        <= '0;
      lineCh          <= '0;
      lineFill        <= 1'b0;
      sel             <= 1'b0;
      ri_writeEnable  <= 1'b0;
      ri_writeAddress <= '0;
      ri_writeChannel <= '0;
      ri_writeData    <= 8'h00;
      cmd_ready       <= 1'b0;
      rw_grant        <= 1'b0;
      busy            <= 1'b1;
      done            <= 1'b0;
    end else begin
      state           <= stateNext;
      walkCnt         <= walkNext;
      waitCnt         <= waitNext;
      lineAddr        <= lineAddrNext;
      lineCh          <= lineChNext;
      lineFill        <= lineFillNext;
      sel             <= selNext;
      ri_writeEnable  <= weNext;
      ri_writeAddress <= addrNext;
      ri_writeChannel <= chNext;
      ri_writeData    <= dataNext;
      cmd_ready       <= readyNext;
      rw_grant        <= grantNext;
      busy            <= busyNext;
      done            <= doneNext;
    end
  end

endmodule

// File: tb/tb_cache_dre_ctrl.sv
// Bench for cache_dre_ctrl at ADDR_WIDTH=4, STARVE_LIMIT=4.
// Control outputs are compared as one vector {sel, we, ready, grant, busy, done}.
// Address, channel and data are compared only in write cycles and in reset.

module tb_cache_dre_ctrl;
  localparam int AW = 4;
  localparam int SL = 4;

  localparam logic [5:0] CTL_WR   = 6'b110010;
  localparam logic [5:0] CTL_WAIT = 6'b000110;
  localparam logic [5:0] CTL_DONE = 6'b001101;
  localparam logic [5:0] CTL_IDLE = 6'b001100;
  localparam logic [5:0] CTL_RST  = 6'b000010;

  typedef struct packed {
    logic [5:0]    ctl;
    logic [AW-1:0] addr;
    logic [1:0]    ch;
    logic [7:0]    data;
  } expT;

  logic          clk, rst, cmd_valid, cmd_ready, rw_req, rw_grant, sel;
  logic [1:0]    cmd_op, cmd_ch, ri_writeChannel;
  logic [AW-1:0] cmd_addr, ri_writeAddress;
  logic          ri_writeEnable, busy, done;
  logic [7:0]    ri_writeData;
  logic [5:0]    ctlObs;

  int nTests;
  int nFail;

  assign ctlObs = {sel, ri_writeEnable, cmd_ready, rw_grant, busy, done};

  cache_dre_ctrl #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_ch(cmd_ch),
    .rw_req(rw_req), .rw_grant(rw_grant), .sel(sel),
    .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
    .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", nTests, nFail);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd9; cmd_ch = 2'd1; rw_req = 1'b1;
    tick(); tick();
    nTests++;
    if (ctlObs !== CTL_RST || ri_writeAddress !== 4'd0 || ri_writeChannel !== 2'd0 || ri_writeData !== 8'h00) begin
      nFail++;
      $display("FAIL reset_values: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=0 ch=0 data=00",
               ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_RST);
    end
    cmd_valid = 1'b0; rw_req = 1'b0; rst = 1'b0;
    for (int w = 0; w < 32; w++) begin
      tick();
      nTests++;
      if (ctlObs !== CTL_WR || ri_writeAddress !== 4'((w / 4) * 2) || ri_writeChannel !== 2'(w % 4) || ri_writeData !== 8'h00) begin
        nFail++;
        $display("FAIL reset_walk[%0d]: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=%h ch=%0d data=00",
                 w, ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR, 4'((w / 4) * 2), w % 4);
      end
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL reset_walk_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_IDLE) begin
      nFail++;
      $display("FAIL reset_idle_after_done: got ctl=%b, want ctl=%b", ctlObs, CTL_IDLE);
    end
  endtask

  task automatic test_fill();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'd5; cmd_ch = 2'd2; rw_req = 1'b0;
    tick();
    cmd_valid = 1'b0;
    nTests++;
    if (ctlObs !== CTL_WAIT) begin
      nFail++;
      $display("FAIL fill_wait: got ctl=%b, want ctl=%b", ctlObs, CTL_WAIT);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_WR || ri_writeAddress !== 4'd5 || ri_writeChannel !== 2'd2 || ri_writeData !== 8'hF0) begin
      nFail++;
      $display("FAIL fill_write: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=5 ch=2 data=f0",
               ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL fill_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_IDLE) begin
      nFail++;
      $display("FAIL fill_idle: got ctl=%b, want ctl=%b", ctlObs, CTL_IDLE);
    end
  endtask

  task automatic test_invalidate_starve();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd4; cmd_ch = 2'd1; rw_req = 1'b1;
    for (int d = 1; d <= SL + 1; d++) begin
      tick();
      cmd_valid = 1'b0;
      nTests++;
      if (ctlObs !== CTL_WAIT) begin
        nFail++;
        $display("FAIL starve_wait[%0d]: got ctl=%b, want ctl=%b", d, ctlObs, CTL_WAIT);
      end
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_WR || ri_writeAddress !== 4'd4 || ri_writeChannel !== 2'd1 || ri_writeData !== 8'h00) begin
      nFail++;
      $display("FAIL starve_write: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=4 ch=1 data=00",
               ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL starve_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
    rw_req = 1'b0;
  endtask

  task automatic test_nop();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 4'd7; cmd_ch = 2'd3;
    tick();
    cmd_valid = 1'b0;
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL nop_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_IDLE) begin
      nFail++;
      $display("FAIL nop_idle: got ctl=%b, want ctl=%b", ctlObs, CTL_IDLE);
    end
  endtask

  task automatic test_flush_busy();
    cmd_valid = 1'b1; cmd_op = 2'b00; rw_req = 1'b1;
    for (int w = 0; w < 32; w++) begin
      tick();
      if (w == 0) begin
        cmd_op = 2'b10; cmd_addr = 4'd3; cmd_ch = 2'd3;
      end
      nTests++;
      if (ctlObs !== CTL_WR || ri_writeAddress !== 4'((w / 4) * 2) || ri_writeChannel !== 2'(w % 4) || ri_writeData !== 8'h00) begin
        nFail++;
        $display("FAIL flush_walk[%0d]: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=%h ch=%0d data=00",
                 w, ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR, 4'((w / 4) * 2), w % 4);
      end
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL flush_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
    tick();
    cmd_valid = 1'b0; rw_req = 1'b0;
    nTests++;
    if (ctlObs !== CTL_WAIT) begin
      nFail++;
      $display("FAIL held_cmd_accept: got ctl=%b, want ctl=%b", ctlObs, CTL_WAIT);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_WR || ri_writeAddress !== 4'd3 || ri_writeChannel !== 2'd3 || ri_writeData !== 8'hF0) begin
      nFail++;
      $display("FAIL held_cmd_write: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=3 ch=3 data=f0",
               ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR);
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL held_cmd_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
  endtask

  task automatic test_reset_mid_flush();
    cmd_valid = 1'b1; cmd_op = 2'b00; rw_req = 1'b0;
    for (int w = 0; w < 10; w++) begin
      tick();
      cmd_valid = 1'b0;
      nTests++;
      if (ctlObs !== CTL_WR || ri_writeAddress !== 4'((w / 4) * 2) || ri_writeChannel !== 2'(w % 4)) begin
        nFail++;
        $display("FAIL abort_pre[%0d]: got ctl=%b addr=%h ch=%0d, want ctl=%b addr=%h ch=%0d",
                 w, ctlObs, ri_writeAddress, ri_writeChannel, CTL_WR, 4'((w / 4) * 2), w % 4);
      end
    end
    rst = 1'b1;
    tick();
    nTests++;
    if (ctlObs !== CTL_RST || ri_writeAddress !== 4'd0 || ri_writeChannel !== 2'd0 || ri_writeData !== 8'h00) begin
      nFail++;
      $display("FAIL abort_reset_values: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=0 ch=0 data=00",
               ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_RST);
    end
    rst = 1'b0;
    for (int w = 0; w < 32; w++) begin
      tick();
      nTests++;
      if (ctlObs !== CTL_WR || ri_writeAddress !== 4'((w / 4) * 2) || ri_writeChannel !== 2'(w % 4) || ri_writeData !== 8'h00) begin
        nFail++;
        $display("FAIL abort_rewalk[%0d]: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=%h ch=%0d data=00",
                 w, ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, CTL_WR, 4'((w / 4) * 2), w % 4);
      end
    end
    tick();
    nTests++;
    if (ctlObs !== CTL_DONE) begin
      nFail++;
      $display("FAIL abort_rewalk_done: got ctl=%b, want ctl=%b", ctlObs, CTL_DONE);
    end
  endtask

  // Reference model: expected per-cycle outputs after accept, derived from
  // the op type, the random rw_req pattern and the starvation bound.
  task automatic test_random();
    expT        q[$];
    expT        x;
    int         r;
    int         k;
    logic [1:0] op;
    logic [3:0] a;
    logic [1:0] c;
    logic [7:0] pat;
    for (int n = 0; n < 30; n++) begin
      r  = int'($urandom_range(0, 7));
      op = (r == 0) ? 2'b00 : (r <= 3) ? 2'b01 : (r <= 6) ? 2'b10 : 2'b11;
      a  = 4'($urandom_range(0, 15));
      c  = 2'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) pat[i] = ($urandom_range(0, 3) != 0);
      q.delete();
      if (op == 2'b00) begin
        for (int e = 0; e < 8; e++) begin
          for (int ch = 0; ch < 4; ch++) begin
            x.ctl = CTL_WR; x.addr = 4'(e * 2); x.ch = 2'(ch); x.data = 8'h00;
            q.push_back(x);
          end
        end
      end else if (op != 2'b11) begin
        k = SL;
        for (int i = SL - 1; i >= 0; i--) if (!pat[i]) k = i;
        for (int i = 0; i <= k; i++) begin
          x.ctl = CTL_WAIT; x.addr = '0; x.ch = '0; x.data = 8'h00;
          q.push_back(x);
        end
        x.ctl  = CTL_WR; x.addr = a; x.ch = c;
        x.data = (op == 2'b01) ? 8'h00 : (a[0] ? 8'hF0 : 8'h0F);
        q.push_back(x);
      end
      x.ctl = CTL_DONE; x.addr = '0; x.ch = '0; x.data = 8'h00;
      q.push_back(x);

      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_ch = c; rw_req = 1'($urandom_range(0, 1));
      tick();
      cmd_valid = 1'b0;
      for (int j = 0; j < q.size(); j++) begin
        x = q[j];
        nTests++;
        if (ctlObs !== x.ctl ||
            (x.ctl == CTL_WR && (ri_writeAddress !== x.addr || ri_writeChannel !== x.ch || ri_writeData !== x.data))) begin
          nFail++;
          $display("FAIL random[%0d] op=%b cyc=%0d: got ctl=%b addr=%h ch=%0d data=%h, want ctl=%b addr=%h ch=%0d data=%h",
                   n, op, j + 1, ctlObs, ri_writeAddress, ri_writeChannel, ri_writeData, x.ctl, x.addr, x.ch, x.data);
        end
        rw_req = (j < 8) ? pat[j] : 1'($urandom_range(0, 1));
        if (j < q.size() - 1) tick();
      end
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_ch = 2'd0; rw_req = 1'b0;
    test_reset();
    test_fill();
    test_invalidate_starve();
    test_nop();
    test_flush_busy();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/cache_dre_ctrl.md
# cache_dre_ctrl

Sequencer and arbiter for the byte-readable (DRE) RAM of the data cache. Owns the `ri_*` write side and the `sel` mux control of `cache_rw_dre`. Clears every DRE bit after reset and on flush, and performs single-line invalidate/fill writes requested by the refill engine. While it owns the RAM, `rw_grant` stalls the cache read/write pipeline; a starvation counter bounds how long a line op can be delayed by pipeline traffic.

## Interface
- `ADDR_WIDTH`, 8, DRE write-address width; matches `cache_rw_dre`.
- `STARVE_LIMIT`, 4, max consecutive cycles a pending line op yields to `rw_req`; range 0..15.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: 00 flush-all, 01 invalidate line, 10 fill line, 11 no-op.
- `cmd_addr` in ADDR_WIDTH: line address; bit 0 selects the half (low/high nibble).
- `cmd_ch` in 2: way/channel.
- `rw_req` in 1: the rw pipeline wants the DRE RAM this cycle.
- `rw_grant` out 1: the rw pipeline may use the RAM; when 0, it stalls.
- `sel` out 1: `cache_rw_dre` mux select; 1 selects `ri_*`.
- `ri_writeAddress` out ADDR_WIDTH, `ri_writeChannel` out 2, `ri_writeEnable` out 1, `ri_writeData` out 8: the DRE write port.
- `busy` out 1: a clear walk or line op is in progress.
- `done` out 1: one-cycle pulse when an operation completes.

## Operation
- States are CLR, IDLE, LINE_WAIT, LINE_WR.
- CLR walks entries e = 0 .. 2^(ADDR_WIDTH-1)-1. For each entry it writes channels 0,1,2,3 in that order, with `ri_writeAddress={e,1'b0}` and `ri_writeData=8'h00`.
  - This is 2^(ADDR_WIDTH+1) writes in total (512 at the default).
  - The channel counter is the inner loop. The 2-bit channel and (ADDR_WIDTH-1)-bit entry counters wrap to 0 after the final write.
- CLR is entered after reset and on flush-all.
- IDLE:
  - `cmd_ready=1`, `sel=0`, `rw_grant=1`.
  - Accepting op 00 enters CLR.
  - Accepting op 01 or 10 latches addr/ch and enters LINE_WAIT.
  - Accepting op 11 stays in IDLE and pulses `done` the next cycle.
- LINE_WAIT:
  - If `rw_req=0`, or the wait counter equals STARVE_LIMIT, go to LINE_WR next cycle.
  - Otherwise increment the wait counter; `rw_grant` stays 1.
  - The wait counter clears on entry to LINE_WAIT.
- LINE_WR: one-cycle write.
  - `sel=1` and `ri_writeEnable=1`, with the latched address and channel.
  - Data is 8'hF0 if addr[0]=1, else 8'h0F, for fill; 8'h00 for invalidate.
  - Next state is IDLE.
- `rw_grant` is the complement of `sel` in every state except during reset.
- `busy` is 1 in CLR, LINE_WAIT and LINE_WR.
- `cmd_ready` is 0 outside IDLE. Commands presented then are held by the requester.

## Timing
- All outputs are registered.
- During `rst`:
  - `sel=0`, `ri_writeEnable=0`, `ri_writeAddress=0`, `ri_writeChannel=0`, `ri_writeData=0`.
  - `cmd_ready=0`, `rw_grant=0`, `busy=1`, `done=0`.
  - State is CLR with counters at 0.
- First cycle after `rst` falls: first clear write (e=0, ch0), `sel=1`.
- Flush accepted at cycle T:
  - Writes occupy T+1 .. T+2^(ADDR_WIDTH+1).
  - The next cycle has `sel=0`, `ri_writeEnable=0`, `done=1`, `cmd_ready=1`.
- Line op accepted at T with `rw_req=0` at T+1: the write happens at T+2, `done` at T+3.
  - Worst case with `rw_req` held high, the write is at T+2+STARVE_LIMIT.
- With STARVE_LIMIT=0, LINE_WAIT always proceeds after one cycle.
- `rst` asserted mid-flush or mid-line-op: the operation is aborted with no `done`, and the clear walk restarts from 0.
- `cmd_valid` asserted together with `rst` is ignored.

## Test plan
- ADDR_WIDTH=4: release reset.
  - Expect 32 writes with data 00.
  - Address/channel sequence: (0,0),(0,1),(0,2),(0,3),(2,0)…(14,3).
  - Then `done` pulses once, `cmd_ready=1` and `rw_grant=1`.
- Fill: addr=5, ch=2, `rw_req=0`.
  - One write at accept+2 with addr 5, ch 2, data F0.
  - `sel` is high for exactly 1 cycle; `done` at accept+3.
- Invalidate under starvation: addr=4, ch=1, `rw_req` held 1, STARVE_LIMIT=4.
  - Write at accept+6, data 00.
  - `rw_grant` is 1 until then and 0 for exactly that cycle.
- Flush accepted while `rw_req=1`.
  - `rw_grant=0` for 2^(ADDR_WIDTH+1) cycles.
  - `cmd_ready=0` throughout; a second command is held until `cmd_ready=1`, then accepted.
- Assert `rst` at the 10th write of a flush.
  - All outputs take reset values the next cycle.
  - No `done` pulse; the walk restarts at (0,0).
- Op 11 accepted: no write, `sel` stays 0, `done` pulses at accept+1.
